// File: rtl/uart_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_link_ctrl
// Purpose  : Byte-stream bridge to a UART slave with an Avalon-MM register
//            map (data reg at address 0, control reg at address 1). It holds
//            one TX byte and one RX byte. The TX byte is sent only when the
//            slave reports write space. RX polling is throttled after an
//            empty read. When both directions are ready, grants alternate.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_clk         in   1   clock, rising edge
//   reset_reset_n   in   1   asynchronous active-low reset
//   avm_address     out  1   0 = data reg, 1 = control reg
//   avm_chipselect  out  1   high for exactly one cycle with each strobe
//   avm_read        out  1   read strobe (slave latency is fixed at 1)
//   avm_write       out  1   write strobe
//   avm_byteenable  out  4   byte lanes of the access
//   avm_writedata   out  32  write data
//   avm_readdata    in   32  read data, valid in the cycle after avm_read
//   tx_data         in   8   byte to send
//   tx_valid        in   1   tx_data valid
//   tx_ready        out  1   TX holding register empty
//   rx_data         out  8   received byte, stable while rx_valid
//   rx_valid        out  1   RX holding register full
//   rx_ready        in   1   consumer takes rx_data
//   busy            out  1   controller is not in IDLE
// ============================================================================
module uart_link_ctrl #(
  parameter int unsigned POLL_GAP = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy
);

  localparam logic       c_ADDR_DATA = 1'b0;
  localparam logic       c_ADDR_CTRL = 1'b1;
  localparam logic       c_GRANT_TX  = 1'b0;
  localparam logic       c_GRANT_RX  = 1'b1;
  localparam logic [7:0] c_POLL_GAP  = 8'(POLL_GAP);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    TX_CHK   = 3'd2,
    TX_CHK_W = 3'd3,
    TX_WR    = 3'd4,
    RX_RD    = 3'd5,
    RX_RD_W  = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        w_grant_nxt;
  logic        r_init_armed;
  logic        r_tx_full;
  logic [7:0]  r_tx_byte;
  logic        r_rx_full;
  logic [7:0]  r_rx_byte;
  logic [7:0]  r_poll_cnt;

  logic        w_tx_pend;
  logic        w_rx_elig;
  logic        w_wspace_nz;
  logic        w_rvalid;
  logic        w_unused;

  assign w_tx_pend   = r_tx_full;
  assign w_rx_elig   = !r_rx_full && (r_poll_cnt == 8'd0);
  assign w_wspace_nz = |avm_readdata[31:16];
  assign w_rvalid    = avm_readdata[15];
  assign w_unused    = ^avm_readdata[14:8];

  assign tx_ready = !r_tx_full;
  assign rx_valid = r_rx_full;
  assign rx_data  = r_rx_byte;
  assign busy     = (r_state != IDLE);

  // --------------------------------------------------------------------------
  // State register. r_init_armed holds back the INIT write for the first
  // cycle after reset. The strobes are decoded from the state, so without
  // it they would be active while reset is still asserted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state      <= INIT;
      r_last_grant <= c_GRANT_RX;
      r_init_armed <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_grant_nxt;
      r_init_armed <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and bus outputs. The bus fields stay at zero unless an access
  // is active.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_last_grant;
    avm_address    = 1'b0;
    avm_chipselect = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_byteenable = 4'b0000;
    avm_writedata  = 32'h0000_0000;

    case (r_state)
      INIT: begin
        if (r_init_armed) begin
          // Control reg = 0: RX/TX interrupts off, polled operation.
          avm_chipselect = 1'b1;
          avm_write      = 1'b1;
          avm_address    = c_ADDR_CTRL;
          avm_byteenable = 4'b1111;
          w_state_nxt    = IDLE;
        end
      end

      IDLE: begin
        if (w_tx_pend && w_rx_elig) begin
          if (r_last_grant == c_GRANT_RX) begin
            w_state_nxt = TX_CHK;
            w_grant_nxt = c_GRANT_TX;
          end else begin
            w_state_nxt = RX_RD;
            w_grant_nxt = c_GRANT_RX;
          end
        end else if (w_tx_pend) begin
          w_state_nxt = TX_CHK;
          w_grant_nxt = c_GRANT_TX;
        end else if (w_rx_elig) begin
          w_state_nxt = RX_RD;
          w_grant_nxt = c_GRANT_RX;
        end
      end

      TX_CHK: begin
        avm_chipselect = 1'b1;
        avm_read       = 1'b1;
        avm_address    = c_ADDR_CTRL;
        avm_byteenable = 4'b1111;
        w_state_nxt    = TX_CHK_W;
      end

      // With no write space, keep the byte. It is retried on the next TX grant.
      TX_CHK_W: w_state_nxt = w_wspace_nz ? TX_WR : IDLE;

      TX_WR: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = c_ADDR_DATA;
        avm_byteenable = 4'b0001;
        avm_writedata  = {24'h00_0000, r_tx_byte};
        w_state_nxt    = IDLE;
      end

      RX_RD: begin
        avm_chipselect = 1'b1;
        avm_read       = 1'b1;
        avm_address    = c_ADDR_DATA;
        avm_byteenable = 4'b1111;
        w_state_nxt    = RX_RD_W;
      end

      RX_RD_W: w_state_nxt = IDLE;

      default: w_state_nxt = INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // TX holding register. A capture cannot coincide with the drain, because
  // tx_ready is low while the byte is held.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_tx_full <= 1'b0;
      r_tx_byte <= 8'h00;
    end else if (r_state == TX_WR) begin
      r_tx_full <= 1'b0;
    end else if (tx_valid && !r_tx_full) begin
      r_tx_full <= 1'b1;
      r_tx_byte <= tx_data;
    end
  end

  // --------------------------------------------------------------------------
  // RX holding register. A load only happens while the register is empty,
  // because the poll is only granted then. So a load never collides with a
  // release.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rx_full <= 1'b0;
      r_rx_byte <= 8'h00;
    end else if (r_state == RX_RD_W && w_rvalid) begin
      r_rx_full <= 1'b1;
      r_rx_byte <= avm_readdata[7:0];
    end else if (r_rx_full && rx_ready) begin
      r_rx_full <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Poll throttle. An empty read reloads the counter. A successful read
  // leaves it at zero, so the next poll can follow once the byte is taken.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_poll_cnt <= 8'd0;
    end else if (r_state == RX_RD_W && !w_rvalid) begin
      r_poll_cnt <= c_POLL_GAP;
    end else if (r_poll_cnt != 8'd0) begin
      r_poll_cnt <= r_poll_cnt - 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_link_ctrl.md
UART_LINK_CTRL -- requirements
Module: uart_link_ctrl

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4, idle cycles between RX polls after an empty read (1..255).
REQ-002 SHALL have port clk_clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset_reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports avm_address  output  1; avm_chipselect, avm_read, avm_write  output  1 each; avm_byteenable  output  4  Avalon master to the UART slave (0 = data reg, 1 = control reg).
REQ-005 SHALL have ports avm_writedata  output  32; avm_readdata  input  32.
REQ-006 SHALL have ports tx_data  input  8; tx_valid  input  1; tx_ready  output  1  byte-send handshake.
REQ-007 SHALL have ports rx_data  output  8; rx_valid  output  1; rx_ready  input  1  byte-receive handshake.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL use states INIT, IDLE, TX_CHK, TX_CHK_W, TX_WR, RX_RD, RX_RD_W.
REQ-010 SHALL treat slave reads as fixed latency 1: read strobe asserted one cycle, avm_readdata sampled in the following (_W) cycle.
REQ-011 SHALL assert avm_chipselect together with every avm_read or avm_write, for exactly one cycle per access, never read and write together.
REQ-012 SHALL in INIT write control reg (address 1, byteenable 4'b1111, writedata 0: RX/TX interrupts disabled), then go IDLE.
REQ-013 SHALL hold one TX byte: tx_ready = TX holding empty; byte captured on tx_valid && tx_ready.
REQ-014 SHALL hold one RX byte: rx_valid = RX holding full; holding cleared on rx_valid && rx_ready; rx_data stable while rx_valid.
REQ-015 SHALL decrement an 8-bit poll counter each cycle while nonzero; RX eligible = RX holding empty && counter == 0.
REQ-016 SHALL in IDLE, with only TX pending, go TX_CHK; only RX eligible, go RX_RD; both, grant opposite of last_grant, then update last_grant.
REQ-017 SHALL in TX_CHK read control reg (address 1); in TX_CHK_W test WSPACE = readdata[31:16].
REQ-018 SHALL on WSPACE != 0 go TX_WR: write address 0, byteenable 4'b0001, writedata {24'b0, held byte}, empty TX holding, go IDLE.
REQ-019 SHALL on WSPACE == 0 go IDLE with byte retained (retry on next TX grant).
REQ-020 SHALL in RX_RD read data reg (address 0, byteenable 4'b1111); in RX_RD_W test RVALID = readdata[15].
REQ-021 SHALL on RVALID = 1 load readdata[7:0] into RX holding, leave counter 0; on RVALID = 0 load counter with POLL_GAP; both return IDLE.
REQ-022 SHALL allow a tx_valid capture or rx_ready release in any state, same cycle as controller activity, without loss.
REQ-023 SHALL drive avm_address, avm_byteenable, avm_writedata to 0 when no access is active.
REQ-024 SHALL never issue a data-reg read while RX holding is full (no popped byte dropped).

Reset
REQ-025 SHALL on reset_reset_n low, asynchronously: state INIT, strobes and chipselect 0, both holdings empty (tx_ready 1 after release, rx_valid 0), rx_data 0, counter 0, last_grant = RX, busy 1.
REQ-026 SHALL on reset mid-access abandon the access immediately and redo INIT after release.

Verification
REQ-027 SHALL test reset release: one control write (addr 1, data 0), then IDLE with busy 0 on cycle 3.
REQ-028 SHALL test TX 0x5A with WSPACE 0x0040: control read, then data write writedata 0x0000005A, byteenable 0001; tx_ready high again after.
REQ-029 SHALL test TX with WSPACE 0 twice then 0x0001: two control reads without write, third grant writes byte once.
REQ-030 SHALL test RX readdata 0x00018041: rx_data 0x41, rx_valid held with rx_ready 0, no further data reads until rx_ready pulse.
REQ-031 SHALL test RX empty (readdata 0x00000000) with POLL_GAP 4: next data read no earlier than 4 cycles after the RX_RD_W cycle.
REQ-032 SHALL test TX pending and RX eligible together: TX serviced first after reset, then grants alternate TX, RX, TX.
